axi_lsu_master: RTL and testbench

// - AXI4-Lite master for the load/store unit; sits directly upstream of the SRAM slave and drives its AR/R/AW/W/B channels.
// - Takes one load or store request at a time from EXU and computes byte lanes, strobes and data alignment.
// - Returns load data or store completion to WBU, with sign/zero extension and an error flag.

---
 rtl/axi_lsu_master.sv | 222 ++++++++++++++++++++++
 tb/tb_axi_lsu_master.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lsu_master.sv
// axi_lsu_master
// AXI4-Lite master for the load/store unit. Accepts one load or store at a
// time from EXU, converts it into a single AXI4-Lite read or write
// transaction, and returns extended load data or a store completion to WBU.
//
// Ports
//   aclk, aresetn                 clock, asynchronous active-low reset
//   req_*                         request from EXU (valid/ready)
//   resp_*                        response to WBU (valid/ready)
//   araddr/arvalid/arready        AXI read address channel
//   rdata/rresp/rvalid/rready     AXI read data channel
//   awaddr/awvalid/awready        AXI write address channel
//   wdata/wstrb/wvalid/wready     AXI write data channel
//   bresp/bvalid/bready           AXI write response channel
//
// Handshake rule on every channel: a transfer happens on a rising clock edge
// where both valid and ready are high. Once raised, a valid and its payload
// stay stable until that edge; ready may be raised or dropped at will.
//
// All AXI and response outputs are registered. req_ready is a pure decode of
// the state register (high only in IDLE).

module axi_lsu_master #(
    parameter int STRB_W = 8
) (
    input  logic              aclk,
    input  logic              aresetn,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [1:0]        req_size,
    input  logic              req_sext,

    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,

    output logic [31:0]       araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [31:0]       rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready,

    output logic [31:0]       awaddr,
    output logic              awvalid,
    input  logic              awready,
    output logic [31:0]       wdata,
    output logic [STRB_W-1:0] wstrb,
    output logic              wvalid,
    input  logic              wready,
    input  logic              bvalid,
    input  logic [1:0]        bresp,
    output logic              bready
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AR   = 3'd1,
        S_R    = 3'd2,
        S_WR   = 3'd3,
        S_B    = 3'd4,
        S_RESP = 3'd5
    } state_t;

    state_t     state;
    logic [1:0] off_q;
    logic [1:0] size_q;
    logic       sext_q;
    logic       aw_done;
    logic       w_done;

    assign req_ready = (state == S_IDLE);

    // Alignment check on the incoming request; size 3 is always illegal.
    logic misaligned;
    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = req_addr[0];
            2'd2:    misaligned = (req_addr[1:0] != 2'b00);
            default: misaligned = 1'b1;
        endcase
    end

    // Store lane placement.
    logic [3:0]  strb_base;
    logic [3:0]  strb_lane;
    logic [31:0] wdata_lane;
    always_comb begin
        strb_base = 4'b0000;
        case (req_size)
            2'd0:    strb_base = 4'b0001;
            2'd1:    strb_base = 4'b0011;
            default: strb_base = 4'b1111;
        endcase
        strb_lane  = strb_base << req_addr[1:0];
        wdata_lane = req_wdata << {req_addr[1:0], 3'b000};
    end

    // Load extraction from the captured offset/size/sext.
    logic [31:0] rd_shift;
    logic [31:0] rd_ext;
    always_comb begin
        rd_shift = rdata >> {off_q, 3'b000};
        rd_ext   = rd_shift;
        case (size_q)
            2'd0:    rd_ext = {{24{sext_q & rd_shift[7]}},  rd_shift[7:0]};
            2'd1:    rd_ext = {{16{sext_q & rd_shift[15]}}, rd_shift[15:0]};
            default: rd_ext = rd_shift;
        endcase
    end

    // Combined "done" view for the write phase: a handshake this cycle counts.
    logic aw_now;
    logic w_now;
    assign aw_now = aw_done | (awvalid & awready);
    assign w_now  = w_done  | (wvalid  & wready);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= S_IDLE;
            off_q      <= 2'b00;
            size_q     <= 2'b00;
            sext_q     <= 1'b0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            arvalid    <= 1'b0;
            rready     <= 1'b0;
            awvalid    <= 1'b0;
            wvalid     <= 1'b0;
            bready     <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'h0;
            araddr     <= 32'h0;
            awaddr     <= 32'h0;
            wdata      <= 32'h0;
            wstrb      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        off_q  <= req_addr[1:0];
                        size_q <= req_size;
                        sext_q <= req_sext;
                        if (misaligned) begin
                            // Reported straight back; the bus is never touched.
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'h0;
                            state      <= S_RESP;
                        end else if (req_wen) begin
                            awaddr  <= {req_addr[31:2], 2'b00};
                            wdata   <= wdata_lane;
                            wstrb   <= {{(STRB_W-4){1'b0}}, strb_lane};
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            aw_done <= 1'b0;
                            w_done  <= 1'b0;
                            state   <= S_WR;
                        end else begin
                            araddr  <= {req_addr[31:2], 2'b00};
                            arvalid <= 1'b1;
                            state   <= S_AR;
                        end
                    end
                end
                S_AR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= S_R;
                    end
                end
                S_R: begin
                    if (rvalid) begin
                        rready     <= 1'b0;
                        resp_rdata <= rd_ext;
                        resp_err   <= (rresp != 2'b00);
                        resp_valid <= 1'b1;
                        state      <= S_RESP;
                    end
                end
                S_WR: begin
                    // AW and W complete independently, in either order.
                    if (awvalid && awready) awvalid <= 1'b0;
                    if (wvalid && wready)   wvalid  <= 1'b0;
                    aw_done <= aw_now;
                    w_done  <= w_now;
                    if (aw_now && w_now) begin
                        bready <= 1'b1;
                        state  <= S_B;
                    end
                end
                S_B: begin
                    if (bvalid) begin
                        bready     <= 1'b0;
                        resp_err   <= (bresp != 2'b00);
                        resp_rdata <= 32'h0;
                        resp_valid <= 1'b1;
                        state      <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lsu_master.sv
// Directed testbench for axi_lsu_master. Each scenario task drives the EXU
// side and plays the AXI slave by hand, then compares outputs against
// hand-computed values. Inputs change and outputs are sampled 1ns after the
// rising edge.

module tb_axi_lsu_master;

    logic        aclk;
    logic        aresetn;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_sext;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [7:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic        bvalid;
    logic [1:0]  bresp;
    logic        bready;

    int checks_total  = 0;
    int checks_passed = 0;

    axi_lsu_master #(.STRB_W(8)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_sext(req_sext),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bresp(bresp), .bready(bready)
    );

    // ---------------- clock / reset ----------------
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    // ---------------- drivers ----------------
    task automatic issue_req(input logic wen, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [1:0] size,
                             input logic sext);
        req_valid = 1'b1;
        req_wen   = wen;
        req_addr  = addr;
        req_wdata = wd;
        req_size  = size;
        req_sext  = sext;
        step();
        req_valid = 1'b0;
    endtask

    // Full load with an always-quick slave; timeouts reported via ok=0.
    task automatic load_txn(input logic [31:0] addr, input logic [1:0] size,
                            input logic sext, input logic [31:0] rd,
                            input logic [1:0] rr,
                            output logic [31:0] got_data, output logic got_err,
                            output logic [31:0] got_araddr, output logic ok);
        ok = 1'b1;
        got_data = 32'h0; got_err = 1'b0; got_araddr = 32'h0;
        issue_req(1'b0, addr, 32'h0, size, sext);
        for (int n = 0; n < 20 && !arvalid; n++) step();
        if (!arvalid) ok = 1'b0;
        got_araddr = araddr;
        arready = 1'b1; step(); arready = 1'b0;
        for (int n = 0; n < 20 && !rready; n++) step();
        if (!rready) ok = 1'b0;
        rvalid = 1'b1; rdata = rd; rresp = rr; step(); rvalid = 1'b0; rresp = 2'b00;
        for (int n = 0; n < 20 && !resp_valid; n++) step();
        if (!resp_valid) ok = 1'b0;
        got_data = resp_rdata; got_err = resp_err;
        resp_ready = 1'b1; step(); resp_ready = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        aresetn = 1'b0;
        step(); step();
        checks_total++;
        if ({arvalid, rready, awvalid, wvalid, bready, resp_valid, resp_err} !== 7'b0)
            $display("FAIL reset_valids: got %b exp 0000000",
                     {arvalid, rready, awvalid, wvalid, bready, resp_valid, resp_err});
        else checks_passed++;
        checks_total++;
        if ({resp_rdata, araddr, awaddr, wdata, wstrb} !== 136'h0)
            $display("FAIL reset_data: rdata=%h araddr=%h awaddr=%h wdata=%h wstrb=%h exp all 0",
                     resp_rdata, araddr, awaddr, wdata, wstrb);
        else checks_passed++;
        aresetn = 1'b1;
        step();
        checks_total++;
        if (req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b exp 1", req_ready);
        else checks_passed++;
    endtask

    task automatic test_load_word();
        issue_req(1'b0, 32'h8000_0004, 32'h0, 2'd2, 1'b0);
        // T1
        checks_total++;
        if (arvalid !== 1'b1 || araddr !== 32'h8000_0004 || req_ready !== 1'b0)
            $display("FAIL lw_ar_t1: arvalid=%b araddr=%h req_ready=%b exp 1 80000004 0",
                     arvalid, araddr, req_ready);
        else checks_passed++;
        arready = 1'b1; step(); arready = 1'b0;
        // T2
        checks_total++;
        if (arvalid !== 1'b0 || rready !== 1'b1)
            $display("FAIL lw_r_t2: arvalid=%b rready=%b exp 0 1", arvalid, rready);
        else checks_passed++;
        rvalid = 1'b1; rdata = 32'hDEAD_BEEF; rresp = 2'b00; step(); rvalid = 1'b0;
        // T3
        checks_total++;
        if (resp_valid !== 1'b1 || resp_rdata !== 32'hDEAD_BEEF || resp_err !== 1'b0 || rready !== 1'b0)
            $display("FAIL lw_resp_t3: valid=%b rdata=%h err=%b rready=%b exp 1 deadbeef 0 0",
                     resp_valid, resp_rdata, resp_err, rready);
        else checks_passed++;
        resp_ready = 1'b1; step(); resp_ready = 1'b0;
        checks_total++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1)
            $display("FAIL lw_done: resp_valid=%b req_ready=%b exp 0 1", resp_valid, req_ready);
        else checks_passed++;
    endtask

    task automatic test_load_byte_ext();
        logic [31:0] d, a;
        logic e, ok;
        load_txn(32'h8000_0003, 2'd0, 1'b1, 32'h80FF_FFFF, 2'b00, d, e, a, ok);
        checks_total++;
        if (!ok || d !== 32'hFFFF_FF80 || e !== 1'b0 || a !== 32'h8000_0000)
            $display("FAIL lb_sext: ok=%b rdata=%h err=%b araddr=%h exp 1 ffffff80 0 80000000",
                     ok, d, e, a);
        else checks_passed++;
        load_txn(32'h8000_0003, 2'd0, 1'b0, 32'h80FF_FFFF, 2'b00, d, e, a, ok);
        checks_total++;
        if (!ok || d !== 32'h0000_0080 || e !== 1'b0)
            $display("FAIL lb_zext: ok=%b rdata=%h err=%b exp 1 00000080 0", ok, d, e);
        else checks_passed++;
        // Half at offset 2, back to back with the byte loads.
        load_txn(32'h8000_0022, 2'd1, 1'b1, 32'h8001_1234, 2'b00, d, e, a, ok);
        checks_total++;
        if (!ok || d !== 32'hFFFF_8001 || a !== 32'h8000_0020)
            $display("FAIL lh_sext: ok=%b rdata=%h araddr=%h exp 1 ffff8001 80000020", ok, d, a);
        else checks_passed++;
        load_txn(32'h8000_0001, 2'd0, 1'b1, 32'h0000_7F00, 2'b00, d, e, a, ok);
        checks_total++;
        if (!ok || d !== 32'h0000_007F)
            $display("FAIL lb_pos_sext: ok=%b rdata=%h exp 1 0000007f", ok, d);
        else checks_passed++;
    endtask

    task automatic test_load_rresp_err();
        logic [31:0] d, a;
        logic e, ok;
        load_txn(32'h8000_0008, 2'd2, 1'b0, 32'h1122_3344, 2'b10, d, e, a, ok);
        checks_total++;
        if (!ok || e !== 1'b1 || d !== 32'h1122_3344)
            $display("FAIL lw_rresp: ok=%b err=%b rdata=%h exp 1 1 11223344", ok, e, d);
        else checks_passed++;
    endtask

    task automatic test_store_half();
        issue_req(1'b1, 32'h8000_0002, 32'h0000_1234, 2'd1, 1'b0);
        checks_total++;
        if (awvalid !== 1'b1 || wvalid !== 1'b1 || awaddr !== 32'h8000_0000 ||
            wdata !== 32'h1234_0000 || wstrb !== 8'h0C)
            $display("FAIL sh_aw_w: awv=%b wv=%b awaddr=%h wdata=%h wstrb=%h exp 1 1 80000000 12340000 0c",
                     awvalid, wvalid, awaddr, wdata, wstrb);
        else checks_passed++;
        awready = 1'b1; wready = 1'b1; step(); awready = 1'b0; wready = 1'b0;
        // bready must stay up while the slave delays the response.
        for (int n = 0; n < 3; n++) begin
            checks_total++;
            if (bready !== 1'b1 || awvalid !== 1'b0 || wvalid !== 1'b0 || resp_valid !== 1'b0)
                $display("FAIL sh_b_wait%0d: bready=%b awv=%b wv=%b resp_valid=%b exp 1 0 0 0",
                         n, bready, awvalid, wvalid, resp_valid);
            else checks_passed++;
            step();
        end
        bvalid = 1'b1; bresp = 2'b00; step(); bvalid = 1'b0;
        checks_total++;
        if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== 32'h0 || bready !== 1'b0)
            $display("FAIL sh_resp: valid=%b err=%b rdata=%h bready=%b exp 1 0 0 0",
                     resp_valid, resp_err, resp_rdata, bready);
        else checks_passed++;
        resp_ready = 1'b1; step(); resp_ready = 1'b0;
    endtask

    task automatic test_store_split();
        issue_req(1'b1, 32'h8000_0041, 32'h0000_00AB, 2'd0, 1'b0);
        checks_total++;
        if (wdata !== 32'h0000_AB00 || wstrb !== 8'h02 || awaddr !== 32'h8000_0040)
            $display("FAIL sb_lane: wdata=%h wstrb=%h awaddr=%h exp 0000ab00 02 80000040",
                     wdata, wstrb, awaddr);
        else checks_passed++;
        wready = 1'b1; step(); wready = 1'b0;
        // W done, AW still pending for three cycles.
        for (int n = 0; n < 3; n++) begin
            checks_total++;
            if (wvalid !== 1'b0 || awvalid !== 1'b1 || bready !== 1'b0 || awaddr !== 32'h8000_0040)
                $display("FAIL split_hold%0d: wv=%b awv=%b bready=%b awaddr=%h exp 0 1 0 80000040",
                         n, wvalid, awvalid, bready, awaddr);
            else checks_passed++;
            if (n < 2) step();
        end
        awready = 1'b1; step(); awready = 1'b0;
        checks_total++;
        if (awvalid !== 1'b0 || bready !== 1'b1)
            $display("FAIL split_b: awv=%b bready=%b exp 0 1", awvalid, bready);
        else checks_passed++;
        bvalid = 1'b1; bresp = 2'b10; step(); bvalid = 1'b0; bresp = 2'b00;
        checks_total++;
        if (bready !== 1'b0 || resp_valid !== 1'b1 || resp_err !== 1'b1)
            $display("FAIL split_resp: bready=%b valid=%b err=%b exp 0 1 1", bready, resp_valid, resp_err);
        else checks_passed++;
        resp_ready = 1'b1; step(); resp_ready = 1'b0;
    endtask

    task automatic test_misaligned();
        issue_req(1'b0, 32'h8000_0001, 32'h0, 2'd2, 1'b0);
        for (int n = 0; n < 4; n++) begin
            checks_total++;
            if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_rdata !== 32'h0 ||
                arvalid !== 1'b0 || req_ready !== 1'b0)
                $display("FAIL mis_hold%0d: valid=%b err=%b rdata=%h arv=%b req_ready=%b exp 1 1 0 0 0",
                         n, resp_valid, resp_err, resp_rdata, arvalid, req_ready);
            else checks_passed++;
            step();
        end
        resp_ready = 1'b1; step(); resp_ready = 1'b0;
        checks_total++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || arvalid !== 1'b0)
            $display("FAIL mis_release: valid=%b req_ready=%b arv=%b exp 0 1 0",
                     resp_valid, req_ready, arvalid);
        else checks_passed++;
        // Illegal size on an aligned store: no AW/W activity.
        issue_req(1'b1, 32'h8000_0010, 32'h0, 2'd3, 1'b0);
        checks_total++;
        if (resp_valid !== 1'b1 || resp_err !== 1'b1 || awvalid !== 1'b0 || wvalid !== 1'b0)
            $display("FAIL size3: valid=%b err=%b awv=%b wv=%b exp 1 1 0 0",
                     resp_valid, resp_err, awvalid, wvalid);
        else checks_passed++;
        resp_ready = 1'b1; step(); resp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_read();
        logic [31:0] d, a;
        logic e, ok;
        issue_req(1'b0, 32'h8000_0020, 32'h0, 2'd2, 1'b0);
        arready = 1'b1; step(); arready = 1'b0;
        checks_total++;
        if (rready !== 1'b1) $display("FAIL rst_pre_r: rready=%b exp 1", rready);
        else checks_passed++;
        #1 aresetn = 1'b0;
        #1;
        checks_total++;
        if ({arvalid, rready, awvalid, wvalid, bready, resp_valid} !== 6'b0)
            $display("FAIL rst_async: valids=%b exp 000000",
                     {arvalid, rready, awvalid, wvalid, bready, resp_valid});
        else checks_passed++;
        step();
        aresetn = 1'b1;
        step();
        checks_total++;
        if (req_ready !== 1'b1) $display("FAIL rst_req_ready: got %b exp 1", req_ready);
        else checks_passed++;
        load_txn(32'h8000_0024, 2'd2, 1'b0, 32'hCAFE_F00D, 2'b00, d, e, a, ok);
        checks_total++;
        if (!ok || d !== 32'hCAFE_F00D || e !== 1'b0 || a !== 32'h8000_0024)
            $display("FAIL rst_new_load: ok=%b rdata=%h err=%b araddr=%h exp 1 cafef00d 0 80000024",
                     ok, d, e, a);
        else checks_passed++;
    endtask

    // ---------------- main sequence and report ----------------
    initial begin
        aresetn = 1'b0;
        req_valid = 1'b0; req_wen = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        req_size = 2'd0; req_sext = 1'b0; resp_ready = 1'b0;
        arready = 1'b0; rdata = 32'h0; rresp = 2'b00; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;

        test_reset();
        test_load_word();
        test_load_byte_ext();
        test_load_rresp_err();
        test_store_half();
        test_store_split();
        test_misaligned();
        test_reset_mid_read();

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

    // Hard stop in case a scenario wedges.
    initial begin
        #50000;
        $display("FAIL timeout: simulation exceeded 50000 ns");
        $display("%0d/%0d checks passed", checks_passed, checks_total + 1);
        $finish;
    end

endmodule
